group4_project_system_sysid_checker: RTL
========================================

// Module: group4_project_system_sysid_checker
// PURPOSE
//  Avalon-MM read master that sequences the system-ID slave after reset (or on request).
//  Reads word 0 (system ID) then word 1 (build timestamp), compares both with expected values, retries on mismatch.
//  Sits beside the sysid slave in the Qsys system; drives pass/fail status to the CPU GPIO/LED and gates boot.
// PARAMETERS
//  EXPECTED_ID     32'd0           value required at address 0
//  EXPECTED_TS     32'd1423252379  value required at address 1
//  MAX_RETRIES     3               extra attempts after first mismatch (0..15)
//  TIMEOUT_CYCLES  255             max waitrequest cycles per read (only with SYSID_CHECK_TIMEOUT_EN)
// PORTS
//  clock          in   1   system clock; all logic on rising edge
//  reset_n        in   1   synchronous active-low reset
//  start          in   1   1-cycle re-check request; ignored while busy=1
//  m_address      out  1   Avalon word address to sysid slave
//  m_read         out  1   Avalon read strobe
//  m_waitrequest  in   1   slave stall; tie 0 for zero-wait sysid
//  m_readdata     in   32  slave read data, valid when m_read & !m_waitrequest
//  busy           out  1   check sequence in progress
//  done           out  1   sequence finished; held until next start
//  pass           out  1   id_ok & ts_ok at done; 0 while busy
//  id_value       out  32  last captured system ID
//  ts_value       out  32  last captured timestamp
//  retry_count    out  4   mismatched attempts in current sequence
//  timeout        out  1   a read timed out (0 when macro off)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE, start_pending=1; all outputs 0 (m_read, m_address, busy, done, pass, id/ts_value, retry_count, timeout).
//  Reset mid-operation: abandon any read immediately (m_read=0 next cycle), restart from IDLE with auto-check pending.
//  FSM states: IDLE, RD_ID, RD_TS, EVAL, DONE.
//   IDLE : if start_pending|start -> RD_ID; clear start_pending, retry_count, timeout, done, pass.
//   RD_ID: m_read=1, m_address=0; on m_read & !m_waitrequest capture id_value <= m_readdata -> RD_TS.
//   RD_TS: m_read=1, m_address=1; on accept capture ts_value -> EVAL.
//   EVAL : match = (id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS).
//          match -> DONE, pass=1. mismatch & retry_count<MAX_RETRIES -> retry_count+1, RD_ID.
//          mismatch & retry_count==MAX_RETRIES -> retry_count+1 (saturate at 15), DONE, pass=0.
//   DONE : done=1; start -> RD_ID with done/pass/retry_count/timeout cleared same edge.
//  m_read/m_address registered; m_read and m_address held stable while m_waitrequest=1 (Avalon rule).
//  busy=1 in RD_ID, RD_TS, EVAL; start while busy is dropped, not queued.
//  Zero-wait latency: done rises on 4th rising edge after reset_n returns high (IDLE,RD_ID,RD_TS,EVAL->DONE).
//  Each retry adds 3 cycles (RD_ID,RD_TS,EVAL). Comparisons full 32-bit, unsigned equality only.
//  start and reset_n=0 same edge: reset wins.
// CONFIGURATION
//  SYSID_CHECK_TIMEOUT_EN defined: 8-bit-min wait counter per read, cleared on entering RD_ID/RD_TS;
//   when count reaches TIMEOUT_CYCLES with m_waitrequest still 1: drop m_read, set timeout=1 (sticky until start),
//   treat as mismatch in EVAL path (retry or fail as above; captured value for that word unchanged).
//  Not defined: no counter; reads wait indefinitely; timeout tied 0.
// TESTING
//  T1 zero-wait slave returning 0 @addr0, 1423252379 @addr1; release reset -> done=1 on edge 4, pass=1, retry_count=0.
//  T2 addr1 returns 32'h0 always -> 4 attempts, done=1 at edge 13, pass=0, retry_count=4, ts_value=0.
//  T3 waitrequest=1 for 5 cycles on each read -> m_read/m_address stable throughout, pass=1, done at edge 14.
//  T4 first attempt addr1 wrong, correct thereafter -> pass=1, retry_count=1, done at edge 7.
//  T5 reset_n=0 one cycle during RD_TS -> m_read=0 next edge, all outputs 0, auto-check reruns and passes.
//  T6 (macro on, TIMEOUT_CYCLES=4, MAX_RETRIES=0) waitrequest stuck 1 -> m_read drops after 4 cycles, timeout=1, done=1, pass=0.

Source files
------------

// File: rtl/group4_project_system_sysid_checker.sv
// Avalon-MM read master that checks the sysid slave (word 0 = ID, word 1 = build timestamp)
// after reset or on start, retrying on mismatch. Optional read timeout: SYSID_CHECK_TIMEOUT_EN.
module group4_project_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1423252379,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count,
    output logic        timeout
);

    typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StEval, StDone} state_e;

    localparam logic [3:0] MaxRetries = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic        start_pending_q, start_pending_d;
    logic        m_read_q, m_read_d;
    logic        m_address_q, m_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic [3:0]  retry_q, retry_d;
    logic        timeout_q, timeout_d;
    logic        att_to_q, att_to_d;
    logic        accept;
    logic        match;
    logic        to_hit;

    assign accept = m_read_q && !m_waitrequest;
    // A timed-out attempt never matches, whatever the stale captured words hold.
    assign match  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS) && !att_to_q;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    assign to_hit = m_read_q && m_waitrequest && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = '0;
        if (m_read_q && m_waitrequest && !to_hit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        start_pending_d = start_pending_q;
        m_read_d        = m_read_q;
        m_address_d     = m_address_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        id_d            = id_q;
        ts_d            = ts_q;
        retry_d         = retry_q;
        timeout_d       = timeout_q;
        att_to_d        = att_to_q;

        case (state_q)
            StIdle, StDone: begin
                if ((state_q == StIdle && start_pending_q) || start) begin
                    state_d         = StRdId;
                    start_pending_d = 1'b0;
                    retry_d         = '0;
                    timeout_d       = 1'b0;
                    att_to_d        = 1'b0;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    busy_d          = 1'b1;
                    m_read_d        = 1'b1;
                    m_address_d     = 1'b0;
                end
            end
            StRdId, StRdTs: begin
                if (accept) begin
                    if (state_q == StRdId) begin
                        id_d        = m_readdata;
                        m_address_d = 1'b1;
                        state_d     = StRdTs;
                    end else begin
                        ts_d     = m_readdata;
                        m_read_d = 1'b0;
                        state_d  = StEval;
                    end
                end else if (to_hit) begin
                    m_read_d  = 1'b0;
                    timeout_d = 1'b1;
                    att_to_d  = 1'b1;
                    state_d   = StEval;
                end
            end
            StEval: begin
                if (match) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (retry_q < MaxRetries) begin
                    retry_d     = retry_q + 4'd1;
                    att_to_d    = 1'b0;
                    state_d     = StRdId;
                    m_read_d    = 1'b1;
                    m_address_d = 1'b0;
                end else begin
                    if (retry_q != 4'hF) begin
                        retry_d = retry_q + 4'd1;
                    end
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            start_pending_q <= 1'b1;
            m_read_q        <= 1'b0;
            m_address_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            id_q            <= '0;
            ts_q            <= '0;
            retry_q         <= '0;
            timeout_q       <= 1'b0;
            att_to_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_pending_q <= start_pending_d;
            m_read_q        <= m_read_d;
            m_address_q     <= m_address_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            id_q            <= id_d;
            ts_q            <= ts_d;
            retry_q         <= retry_d;
            timeout_q       <= timeout_d;
            att_to_q        <= att_to_d;
        end
    end

    assign m_read      = m_read_q;
    assign m_address   = m_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign retry_count = retry_q;
    assign timeout     = timeout_q;

endmodule
